serial_subtractor: RTL and testbench

//  Bit-serial unsigned subtractor. It is the inverse-direction companion of the
//  1-bit full-adder datapath in the adder library.
//  - Accepts two WIDTH-bit operands on a start pulse.
//  - Produces DIFF = A - B, LSB first, one bit per clock, through a single 1-bit

---
 rtl/adder_pkg.sv | 14 +
 rtl/full_subtractor_1.sv | 18 +
 rtl/serial_subtractor.sv | 91 +++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder/subtractor family.
//   ST_*   : FSM state encodings (2-bit, legacy-compatible constants)
//   CNT_W  : bit-counter width for a given operand width (clog2, min 1)
package adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int CNT_W(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_1.sv
// Combinational 1-bit full-subtractor cell: X - Y - Bin.
//   X, Y  : operand bits
//   Bin   : borrow in
//   D     : difference bit
//   Bout  : borrow out
module full_subtractor_1 (
  input  logic X,
  input  logic Y,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = X ^ Y ^ Bin;
  // Borrow when X<Y outright, or when X==Y and a borrow is already pending.
  assign Bout = (~X & Y) | (~(X ^ Y) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a_in - b_in, LSB first, one bit per
// clock through a single full-subtractor cell and a registered borrow.
//   clk1, rst_n        : clock (rising edge), async active-low reset
//   start              : request, honoured only in IDLE or DONE
//   a_in, b_in         : operands, captured on an accepted start
//   busy               : high during SHIFT
//   done               : one-cycle pulse, diff/borrow valid
//   diff, borrow       : result and final borrow (1 iff a_in < b_in)
//   bit_out, bit_valid : serial difference bit of this cycle, and its qualifier
module serial_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             bit_out,
  output logic             bit_valid
);

  localparam int            CW       = CNT_W(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic             d, bout;

  full_subtractor_1 u_cell (
    .X    (a_sr[0]),
    .Y    (b_sr[0]),
    .Bin  (bin),
    .D    (d),
    .Bout (bout)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        // DONE accepts start exactly like IDLE so results can run back-to-back.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            bin    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            state  <= ST_SHIFT;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          diff <= {d, diff[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          bin  <= bout;
          cnt  <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            borrow <= bout;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_SHIFT);
  assign done      = (state == ST_DONE);
  assign bit_valid = busy;
  assign bit_out   = busy & d;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk1 = 1'b0;
  logic       rst_n;
  // WIDTH=8 instance
  logic       start;
  logic [7:0] a_in, b_in, diff;
  logic       busy, done, borrow, bit_out, bit_valid;
  // WIDTH=2 instance
  logic       start2;
  logic [1:0] a2, b2, diff2;
  logic       busy2, done2, borrow2, bit_out2, bit_valid2;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk1 = ~clk1;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
    .bit_out(bit_out), .bit_valid(bit_valid)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk1(clk1), .rst_n(rst_n), .start(start2), .a_in(a2), .b_in(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2),
    .bit_out(bit_out2), .bit_valid(bit_valid2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  // Start an 8-bit operation at a negedge, then count negedges until done.
  // lat is the number of edges between the accepting edge and done rising.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat,
                        output logic [7:0] bits);
    int cyc;
    @(negedge clk1);
    start = 1'b1; a_in = a; b_in = b;
    cyc = 0;
    bits = '0;
    do begin
      @(negedge clk1);
      start = 1'b0; a_in = 8'hxx; b_in = 8'hxx;
      if (bit_valid && cyc < 8) bits[cyc] = bit_out;
      cyc++;
    end while (!done && cyc < 40);
    lat = cyc - 1;
    if (!done) begin
      total++;
      $display("FAIL done_timeout: no done within %0d cycles", cyc);
    end
  endtask

  initial begin
    vec_t       vecs[7];
    int         lat, ndone, cyc;
    logic [7:0] bits;
    logic [7:0] ea;

    vecs[0] = '{a:8'd200, b:8'd55,  d:8'd145, bo:1'b0};
    vecs[1] = '{a:8'd5,   b:8'd9,   d:8'd252, bo:1'b1};
    vecs[2] = '{a:8'd0,   b:8'd1,   d:8'd255, bo:1'b1};
    vecs[3] = '{a:8'd170, b:8'd170, d:8'd0,   bo:1'b0};
    vecs[4] = '{a:8'd255, b:8'd0,   d:8'd255, bo:1'b0};
    vecs[5] = '{a:8'd0,   b:8'd255, d:8'd1,   bo:1'b1};
    vecs[6] = '{a:8'd128, b:8'd127, d:8'd1,   bo:1'b0};

    start = 0; a_in = 0; b_in = 0; start2 = 0; a2 = 0; b2 = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    check("rst_bit", {bit_out, bit_valid}, 0);
    rst_n = 1'b1;

    // Table-driven results
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, bits);
      check($sformatf("v%0d_lat", i), lat, 8);
      check($sformatf("v%0d_diff", i), diff, vecs[i].d);
      check($sformatf("v%0d_borrow", i), borrow, vecs[i].bo);
      if (i == 0) check("v0_bitseq", bits, 8'b1001_0001);
      @(negedge clk1);
      check($sformatf("v%0d_done_drop", i), done, 0);
      check($sformatf("v%0d_hold", i), diff, vecs[i].d);
    end

    // start during SHIFT is ignored
    @(negedge clk1);
    start = 1'b1; a_in = 8'd200; b_in = 8'd55;
    ndone = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk1);
      if (done) begin
        ndone++;
        check("ign_lat", c, 9);
        check("ign_diff", diff, 145);
        check("ign_borrow", borrow, 0);
      end
      start = (c == 3 || c == 5);
      a_in = 8'd1; b_in = 8'd1;
    end
    start = 1'b0;
    check("ign_ndone", ndone, 1);
    repeat (12) @(negedge clk1);
    check("ign_no_restart", {busy, done}, 0);

    // Reset mid-SHIFT aborts
    @(negedge clk1);
    start = 1'b1; a_in = 8'd200; b_in = 8'd55;
    @(negedge clk1);
    start = 1'b0;
    repeat (4) @(negedge clk1);
    check("abort_busy_pre", busy, 1);
    check("abort_diff_pre_nz", (diff != 0), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow, 0);
    check("abort_bitv", bit_valid, 0);
    @(negedge clk1);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk1);
      if (done || busy) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(8'd10, 8'd3, lat, bits);
    check("post_rst_diff", diff, 7);
    check("post_rst_borrow", borrow, 0);

    // Back-to-back: start held on the done cycle
    @(negedge clk1);
    run_op(8'd200, 8'd55, lat, bits);
    check("b2b_first", diff, 145);
    start = 1'b1; a_in = 8'd1; b_in = 8'd2;
    cyc = 0;
    do begin
      @(negedge clk1);
      if (cyc == 0) begin
        start = 1'b0;
        check("b2b_no_gap", busy, 1);
        check("b2b_done_drop", done, 0);
        check("b2b_cleared", diff, 0);
      end
      cyc++;
    end while (!done && cyc < 40);
    check("b2b_lat", cyc, 9);
    check("b2b_diff", diff, 255);
    check("b2b_borrow", borrow, 1);
    @(negedge clk1);

    // WIDTH=2 exhaustive
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk1);
        start2 = 1'b1; a2 = 2'(a); b2 = 2'(b);
        cyc = 0;
        do begin
          @(negedge clk1);
          start2 = 1'b0;
          cyc++;
        end while (!done2 && cyc < 20);
        ea = 8'(a - b);
        check($sformatf("w2_%0d_%0d_lat", a, b), cyc - 1, 2);
        check($sformatf("w2_%0d_%0d_diff", a, b), diff2, {30'd0, ea[1:0]});
        check($sformatf("w2_%0d_%0d_borrow", a, b), borrow2, (a < b) ? 1 : 0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
